cp0_irq_ctrl: RTL and testbench
===============================

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 SHALL have: clk  input  1  system clock; all state updates on the rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: hw_int  input  6  asynchronous, level-sensitive hardware interrupt lines 5..0.
REQ-004 SHALL have: status_in  input  32  live CP0 Status value; uses IE[0], EXL[1], ERL[2], IM[15:8].
REQ-005 SHALL have: sw_ip_we  input  1  MTC0 to Cause; loads software pending bits.
REQ-006 SHALL have: count_we  input  1  MTC0 to Count.
REQ-007 SHALL have: compare_we  input  1  MTC0 to Compare.
REQ-008 SHALL have: wdata  input  32  MTC0 write data; Cause write uses wdata[9:8].
REQ-009 SHALL have: int_ack  input  1  pipeline accepts the interrupt (exception taken, cause Int).
REQ-010 SHALL have: eret  input  1  ERET retired.
REQ-011 SHALL have: irq_req  output  1  interrupt request to the pipeline.
REQ-012 SHALL have: cause_ip  output  8  Cause[15:8] pending bits, for MFC0.
REQ-013 SHALL have: count  output  32  Count register.
REQ-014 SHALL have: compare  output  32  Compare register.
REQ-015 SHALL have: timer_int  output  1  timer interrupt flag.

Function
REQ-016 SHALL pass each hw_int bit through a 2-flop synchronizer; a level reaches cause_ip on the 2nd rising edge after it is sampled.
REQ-017 SHALL form cause_ip[7:2] = sync_hw[5:0], with cause_ip[7] = sync_hw[5] OR timer_int.
REQ-018 SHALL hold cause_ip[1:0] in a register; on sw_ip_we it loads wdata[9:8]; otherwise it holds.
REQ-019 SHALL toggle an internal tick flop every cycle; count increments by 1 on cycles where tick=1 (every 2nd cycle); 0xFFFFFFFF wraps to 0.
REQ-020 SHALL on count_we load count with wdata and suppress that cycle's increment (write wins).
REQ-021 SHALL set timer_int on the edge where the increment makes count equal compare; timer_int is sticky.
REQ-022 SHALL on compare_we load compare with wdata and clear timer_int; if a match occurs in the same cycle, the clear wins.
REQ-023 SHALL define enable = IE & ~EXL & ~ERL and pending = |(cause_ip & IM).
REQ-024 SHALL implement the FSM IDLE, REQ, WAIT_ERET; irq_req = (state==REQ).
REQ-025 SHALL transition IDLE->REQ on the edge where pending & enable are both 1; irq_req rises 1 cycle after the condition.
REQ-026 SHALL in REQ: go to WAIT_ERET if int_ack=1; else go to IDLE if pending or enable dropped (withdraw); else hold. int_ack takes priority over the withdraw.
REQ-027 SHALL in WAIT_ERET: keep irq_req=0 and go to IDLE on eret.
REQ-028 SHALL ignore int_ack outside REQ and eret outside WAIT_ERET.
REQ-029 SHALL keep count, compare and timer_int running and updating independently of FSM state.

Reset
REQ-030 SHALL on reset clear: synchronizers, cause_ip[1:0], tick, count, compare, timer_int; set state to IDLE; drive irq_req=0.
REQ-031 SHALL let reset asserted mid-REQ or mid-WAIT_ERET return the FSM to IDLE on the next edge, with no pending ack retained.

Verification
REQ-032 SHALL verify HW interrupt: status_in=0x00000401, hw_int[0] 0->1 -> cause_ip[2]=1 after 2 edges, irq_req=1 one edge later; int_ack=1 -> irq_req=0; eret -> IDLE.
REQ-033 SHALL verify masking: hw_int=6'h3F with IM=0x00 or EXL=1 -> irq_req stays 0; raising IM[2] with IE=1, EXL=0 -> irq_req=1.
REQ-034 SHALL verify timer: count_we wdata=0x10, compare_we wdata=0x12 -> timer_int=1 and cause_ip[7]=1 after 4 cycles; compare_we -> timer_int=0.
REQ-035 SHALL verify withdraw: in REQ, deassert hw_int or clear IE before int_ack -> IDLE on the next edge, irq_req=0.
REQ-036 SHALL verify software IP and wrap: sw_ip_we wdata=0x200 with IM[1]=1 -> cause_ip=0x02, irq_req=1; count=0xFFFFFFFF, 2 cycles -> count=0.
REQ-037 SHALL verify simultaneous events: count_we during a tick cycle -> count=wdata exactly; compare_we on a match edge -> timer_int=0.

Source files
------------

// File: rtl/cp0_irq_ctrl_if.sv
// Bus bundle between the CP0 interrupt controller and the pipeline/CP0 register file.
// The master drives MTC0 writes, interrupt lines and handshakes; the slave returns request and register state.
interface cp0_irq_ctrl_if;
  logic [5:0]  hw_int;
  logic [31:0] status_in;
  logic        sw_ip_we;
  logic        count_we;
  logic        compare_we;
  logic [31:0] wdata;
  logic        int_ack;
  logic        eret;
  logic        irq_req;
  logic [7:0]  cause_ip;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;

  modport master (
    output hw_int, status_in, sw_ip_we, count_we, compare_we, wdata, int_ack, eret,
    input  irq_req, cause_ip, count, compare, timer_int
  );

  modport slave (
    input  hw_int, status_in, sw_ip_we, count_we, compare_we, wdata, int_ack, eret,
    output irq_req, cause_ip, count, compare, timer_int
  );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: synchronized HW lines, software pending bits, Count/Compare timer
// and a request/acknowledge/ERET handshake FSM toward the pipeline.
module cp0_irq_ctrl (
  input logic           clk,
  input logic           reset,
  cp0_irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_ERET = 2'd2
  } state_t;

  logic [5:0]  sync1_reg;
  logic [5:0]  sync2_reg;
  logic [1:0]  sw_ip_reg;
  logic        tick_reg;
  logic [31:0] count_reg;
  logic [31:0] count_next;
  logic [31:0] count_inc;
  logic [31:0] compare_reg;
  logic        timer_reg;
  logic        timer_next;
  logic        timer_match;
  logic [7:0]  cause_ip;
  logic        enable;
  logic        pending;
  logic        take;
  state_t      state_reg;
  state_t      state_next;

  // Only IE/EXL/ERL and IM are consumed from Status.
  logic unused_status;
  assign unused_status = ^{bus.status_in[31:16], bus.status_in[7:3]};

  // Two-flop synchronizer per hardware line.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= bus.hw_int[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_ip_reg <= 2'b00;
    end else if (bus.sw_ip_we) begin
      sw_ip_reg <= bus.wdata[9:8];
    end
  end

  // Timer interrupt shares IP7 with hardware line 5.
  always_comb begin
    cause_ip      = {sync2_reg, sw_ip_reg};
    cause_ip[7]   = sync2_reg[5] | timer_reg;
  end

  always_comb begin
    count_inc   = count_reg + 32'd1;
    count_next  = count_reg;
    timer_match = 1'b0;
    if (bus.count_we) begin
      count_next = bus.wdata;
    end else if (tick_reg) begin
      count_next  = count_inc;
      timer_match = (count_inc == compare_reg);
    end
    timer_next = timer_reg;
    if (bus.compare_we) begin
      timer_next = 1'b0;
    end else if (timer_match) begin
      timer_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_reg    <= 1'b0;
      count_reg   <= 32'd0;
      compare_reg <= 32'd0;
      timer_reg   <= 1'b0;
    end else begin
      tick_reg  <= ~tick_reg;
      count_reg <= count_next;
      timer_reg <= timer_next;
      if (bus.compare_we) begin
        compare_reg <= bus.wdata;
      end
    end
  end

  assign enable  = bus.status_in[0] & ~bus.status_in[1] & ~bus.status_in[2];
  assign pending = |(cause_ip & bus.status_in[15:8]);
  assign take    = pending & enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Acknowledge beats withdrawal when both happen in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (take) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.int_ack) begin
          state_next = S_WAIT_ERET;
        end else if (!take) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT_ERET: begin
        if (bus.eret) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.irq_req   = (state_reg == S_REQ);
  assign bus.cause_ip  = cause_ip;
  assign bus.count     = count_reg;
  assign bus.compare   = compare_reg;
  assign bus.timer_int = timer_reg;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: a vector table for cause/mask decoding plus hand
// sequences for the handshake, withdraw, timer match, wrap and reset corner cases.
module tb_cp0_irq_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cp0_irq_ctrl_if bus ();

  cp0_irq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  hw;
    logic [31:0] status;
    logic        sw_we;
    logic [31:0] wd;
    logic [7:0]  exp_cause;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus.hw_int     = 6'h00;
    bus.status_in  = 32'h0;
    bus.sw_ip_we   = 1'b0;
    bus.count_we   = 1'b0;
    bus.compare_we = 1'b0;
    bus.wdata      = 32'h0;
    bus.int_ack    = 1'b0;
    bus.eret       = 1'b0;
  endtask

  // Leaves tick=0 before the first post-reset edge.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clear_inputs();
    step(2);
    reset = 1'b0;

    // Reset state
    check("rst_irq", {31'd0, bus.irq_req}, 32'd0);
    check("rst_cause", {24'd0, bus.cause_ip}, 32'd0);
    check("rst_count", bus.count, 32'd0);
    check("rst_compare", bus.compare, 32'd0);
    check("rst_timer", {31'd0, bus.timer_int}, 32'd0);

    // Cause decoding and masking table
    vecs[0] = '{6'h01, 32'h0000_0401, 1'b0, 32'h000, 8'h04, 1'b1};
    vecs[1] = '{6'h3F, 32'h0000_0001, 1'b0, 32'h000, 8'hFC, 1'b0};
    vecs[2] = '{6'h3F, 32'h0000_FF03, 1'b0, 32'h000, 8'hFC, 1'b0};
    vecs[3] = '{6'h3F, 32'h0000_FF05, 1'b0, 32'h000, 8'hFC, 1'b0};
    vecs[4] = '{6'h3F, 32'h0000_FF00, 1'b0, 32'h000, 8'hFC, 1'b0};
    vecs[5] = '{6'h20, 32'h0000_8001, 1'b0, 32'h000, 8'h80, 1'b1};
    vecs[6] = '{6'h02, 32'h0000_0401, 1'b0, 32'h000, 8'h08, 1'b0};
    vecs[7] = '{6'h00, 32'h0000_0201, 1'b1, 32'h200, 8'h02, 1'b1};
    vecs[8] = '{6'h00, 32'h0000_0201, 1'b1, 32'h100, 8'h01, 1'b0};
    vecs[9] = '{6'h10, 32'h0000_4001, 1'b1, 32'h300, 8'h43, 1'b1};

    for (int v = 0; v < 10; v++) begin
      do_reset();
      bus.hw_int    = vecs[v].hw;
      bus.status_in = vecs[v].status;
      bus.sw_ip_we  = vecs[v].sw_we;
      bus.wdata     = vecs[v].wd;
      step(1);
      bus.sw_ip_we  = 1'b0;
      step(3);
      check($sformatf("vec%0d_cause", v), {24'd0, bus.cause_ip}, {24'd0, vecs[v].exp_cause});
      check($sformatf("vec%0d_irq", v), {31'd0, bus.irq_req}, {31'd0, vecs[v].exp_irq});
    end

    // HW interrupt handshake: sync latency, ack, ERET
    do_reset();
    bus.status_in = 32'h0000_0401;
    bus.hw_int    = 6'h01;
    step(1);
    check("hs_cause_e1", {31'd0, bus.cause_ip[2]}, 32'd0);
    step(1);
    check("hs_cause_e2", {31'd0, bus.cause_ip[2]}, 32'd1);
    check("hs_irq_e2", {31'd0, bus.irq_req}, 32'd0);
    step(1);
    check("hs_irq_e3", {31'd0, bus.irq_req}, 32'd1);
    bus.int_ack = 1'b1;
    step(1);
    bus.int_ack = 1'b0;
    check("hs_irq_acked", {31'd0, bus.irq_req}, 32'd0);
    step(2);
    check("hs_wait_hold", {31'd0, bus.irq_req}, 32'd0);
    bus.eret = 1'b1;
    step(1);
    bus.eret = 1'b0;
    check("hs_eret_idle", {31'd0, bus.irq_req}, 32'd0);
    step(1);
    check("hs_rereq", {31'd0, bus.irq_req}, 32'd1);

    // Withdraw by clearing IE
    bus.status_in = 32'h0000_0400;
    step(1);
    check("wd_ie_irq", {31'd0, bus.irq_req}, 32'd0);

    // Withdraw by dropping the HW line (synchronizer delays the drop)
    bus.status_in = 32'h0000_0401;
    step(1);
    check("wd_hw_req", {31'd0, bus.irq_req}, 32'd1);
    bus.hw_int = 6'h00;
    step(2);
    check("wd_hw_still", {31'd0, bus.irq_req}, 32'd1);
    step(1);
    check("wd_hw_irq", {31'd0, bus.irq_req}, 32'd0);

    // Ack wins over simultaneous withdraw
    bus.hw_int = 6'h01;
    step(3);
    check("pri_req", {31'd0, bus.irq_req}, 32'd1);
    bus.int_ack   = 1'b1;
    bus.status_in = 32'h0000_0400;
    step(1);
    bus.int_ack   = 1'b0;
    bus.status_in = 32'h0000_0401;
    step(2);
    check("pri_wait", {31'd0, bus.irq_req}, 32'd0);
    bus.eret = 1'b1;
    step(2);
    bus.eret = 1'b0;
    check("pri_after_eret", {31'd0, bus.irq_req}, 32'd1);

    // Reset mid-WAIT_ERET returns to IDLE; request re-forms after sync latency
    bus.int_ack = 1'b1;
    step(1);
    bus.int_ack = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_wait_irq", {31'd0, bus.irq_req}, 32'd0);
    check("rst_wait_cause", {24'd0, bus.cause_ip}, 32'd0);
    step(3);
    check("rst_wait_rereq", {31'd0, bus.irq_req}, 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_req_irq", {31'd0, bus.irq_req}, 32'd0);

    // Timer match and stickiness
    do_reset();
    bus.count_we = 1'b1;
    bus.wdata    = 32'h10;
    step(1);
    bus.count_we = 1'b0;
    check("tm_count_load", bus.count, 32'h10);
    bus.compare_we = 1'b1;
    bus.wdata      = 32'h12;
    step(1);
    bus.compare_we = 1'b0;
    check("tm_count_inc", bus.count, 32'h11);
    check("tm_compare", bus.compare, 32'h12);
    step(1);
    check("tm_timer_pre", {31'd0, bus.timer_int}, 32'd0);
    step(1);
    check("tm_timer_set", {31'd0, bus.timer_int}, 32'd1);
    check("tm_cause7", {31'd0, bus.cause_ip[7]}, 32'd1);
    check("tm_count_match", bus.count, 32'h12);
    step(2);
    check("tm_sticky", {31'd0, bus.timer_int}, 32'd1);
    bus.compare_we = 1'b1;
    bus.wdata      = 32'h100;
    step(1);
    bus.compare_we = 1'b0;
    check("tm_clear", {31'd0, bus.timer_int}, 32'd0);
    check("tm_cause7_clr", {31'd0, bus.cause_ip[7]}, 32'd0);

    // Simultaneous events: count write on tick cycle, compare write on match edge
    do_reset();
    bus.compare_we = 1'b1;
    bus.wdata      = 32'h21;
    step(1);
    bus.compare_we = 1'b0;
    bus.count_we   = 1'b1;
    bus.wdata      = 32'h20;
    step(1);
    bus.count_we = 1'b0;
    check("sim_count_we", bus.count, 32'h20);
    step(1);
    bus.compare_we = 1'b1;
    bus.wdata      = 32'h21;
    step(1);
    bus.compare_we = 1'b0;
    check("sim_match_count", bus.count, 32'h21);
    check("sim_clear_wins", {31'd0, bus.timer_int}, 32'd0);
    step(2);
    check("sim_past", {31'd0, bus.timer_int}, 32'd0);

    // Count wrap (compare=0, so the wrap also matches)
    do_reset();
    bus.count_we = 1'b1;
    bus.wdata    = 32'hFFFF_FFFF;
    step(1);
    bus.count_we = 1'b0;
    check("wrap_load", bus.count, 32'hFFFF_FFFF);
    step(1);
    check("wrap_zero", bus.count, 32'h0);
    check("wrap_timer", {31'd0, bus.timer_int}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
